// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8-N-1 serial receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  // Oversample divider, floored; never below one clock per tick.
  function automatic int calc_div(input int clk_freq, input int baud, input int osr);
    int d;
    d = clk_freq / (baud * osr);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, held at zero while cleared.
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clr_i || (cnt_q == LAST)) cnt_d = '0;
    else                          cnt_d = cnt_q + CW'(1);
  end

  assign tick_o = !clr_i && (cnt_q == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rcvr_top.sv
// 8-N-1 serial receiver with a one-byte receive buffer, framing-error and sticky overflow flags.
module uart_rcvr_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int OSR      = 16
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic       Rx_raw,
  input  logic       Rd_en,
  input  logic       clr_ovrflw,
  output logic [7:0] rx_data_out,
  output logic       SFE,
  output logic       d_valid,
  output logic       overflow
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OSR);
  localparam int OW  = $clog2(OSR);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [OW-1:0] OS_HALF  = OW'(OSR / 2 - 1);
  localparam logic [OW-1:0] OS_LAST  = OW'(OSR - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic                 sync1_q, rx_s_q;
  rx_state_e            state_q;
  logic [OW-1:0]        os_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q, rbr_q;
  logic                 sfe_q, dv_q, ovf_q;
  logic                 tick, stop_smp, accept;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_i  (CLOCK),
    .rst_i  (reset),
    .clr_i  (state_q == IDLE),
    .tick_o (tick)
  );

  // A read in the same cycle as the stop sample frees the buffer for the new byte.
  assign stop_smp = (state_q == STOP) && tick && (os_cnt_q == OS_LAST);
  assign accept   = !dv_q || Rd_en;

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rbr_q     <= '0;
      sfe_q     <= 1'b0;
      dv_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync1_q <= Rx_raw;
      rx_s_q  <= sync1_q;

      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q  <= START;
            os_cnt_q <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (os_cnt_q == OS_HALF) begin
              os_cnt_q  <= '0;
              bit_cnt_q <= '0;
              state_q   <= rx_s_q ? IDLE : DATA;
            end else begin
              os_cnt_q <= os_cnt_q + OW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (os_cnt_q == OS_LAST) begin
              os_cnt_q  <= '0;
              shift_q   <= {rx_s_q, shift_q[DATA_BITS-1:1]};
              bit_cnt_q <= bit_cnt_q + BW'(1);
              if (bit_cnt_q == BIT_LAST) state_q <= STOP;
            end else begin
              os_cnt_q <= os_cnt_q + OW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (os_cnt_q == OS_LAST) begin
              os_cnt_q <= '0;
              state_q  <= IDLE;
            end else begin
              os_cnt_q <= os_cnt_q + OW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (stop_smp && accept) begin
        rbr_q <= shift_q;
        sfe_q <= !rx_s_q;
        dv_q  <= 1'b1;
      end else if (Rd_en && dv_q) begin
        dv_q  <= 1'b0;
        sfe_q <= 1'b0;
      end

      if (stop_smp && !accept) ovf_q <= 1'b1;
      else if (clr_ovrflw)     ovf_q <= 1'b0;
    end
  end

  assign rx_data_out = rbr_q;
  assign SFE         = sfe_q;
  assign d_valid     = dv_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_uart_rcvr_top.sv
// Directed bench for uart_rcvr_top: frame table plus hand-written corner sequences.
module tb_uart_rcvr_top;

  localparam int BAUD     = 1_000_000;
  localparam int CLK_FREQ = 64 * BAUD;
  localparam int OSR      = 16;
  localparam int BIT_CLKS = 64;
  localparam int LAT      = 611;

  logic       CLOCK = 1'b0;
  logic       reset = 1'b1;
  logic       Rx_raw = 1'b1;
  logic       Rd_en = 1'b0;
  logic       clr_ovrflw = 1'b0;
  logic [7:0] rx_data_out;
  logic       SFE, d_valid, overflow;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_cyc = -1;
  int   frame_start = 0;
  logic dv_last = 1'b0;

  uart_rcvr_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OSR(OSR)) dut (
    .CLOCK       (CLOCK),
    .reset       (reset),
    .Rx_raw      (Rx_raw),
    .Rd_en       (Rd_en),
    .clr_ovrflw  (clr_ovrflw),
    .rx_data_out (rx_data_out),
    .SFE         (SFE),
    .d_valid     (d_valid),
    .overflow    (overflow)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc++;

  always @(negedge CLOCK) begin
    if (d_valid && !dv_last) rise_cyc = cyc;
    dv_last = d_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       rd_after;
    logic       clr_after;
    logic [7:0] exp_data;
    logic       exp_sfe;
    logic       exp_dv;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Start bit, 8 data bits LSB first, stop bit, then an idle gap.
  task automatic send_frame(input logic [7:0] data, input logic stop);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge CLOCK);
      #1;
      if (i == 0) begin
        frame_start = cyc;
        rise_cyc    = -1;
      end
      Rx_raw = bits[i];
      repeat (BIT_CLKS - 1) @(posedge CLOCK);
    end
    @(posedge CLOCK);
    #1 Rx_raw = 1'b1;
    repeat (BIT_CLKS) @(posedge CLOCK);
  endtask

  task automatic pulse_rd();
    @(posedge CLOCK);
    #1 Rd_en = 1'b1;
    @(posedge CLOCK);
    #1 Rd_en = 1'b0;
    @(negedge CLOCK);
  endtask

  task automatic pulse_clr();
    @(posedge CLOCK);
    #1 clr_ovrflw = 1'b1;
    @(posedge CLOCK);
    #1 clr_ovrflw = 1'b0;
    @(negedge CLOCK);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1};

    repeat (4) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("reset rx_data_out", rx_data_out, 8'h00);
    chk("reset SFE", SFE, 1'b0);
    chk("reset d_valid", d_valid, 1'b0);
    chk("reset overflow", overflow, 1'b0);
    @(posedge CLOCK);
    #1 reset = 1'b0;
    repeat (5) @(posedge CLOCK);

    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].data, vecs[i].stop);
      @(negedge CLOCK);
      chk($sformatf("v%0d rx_data_out", i), rx_data_out, vecs[i].exp_data);
      chk($sformatf("v%0d SFE", i), SFE, vecs[i].exp_sfe);
      chk($sformatf("v%0d d_valid", i), d_valid, vecs[i].exp_dv);
      chk($sformatf("v%0d overflow", i), overflow, vecs[i].exp_ovf);
      if (i == 0) begin
        checks++;
        if ((rise_cyc - frame_start) < LAT - 1 || (rise_cyc - frame_start) > LAT + 1) begin
          errors++;
          $display("FAIL v0 latency: got %0d clocks want %0d +/-1", rise_cyc - frame_start, LAT);
        end
      end
      if (vecs[i].clr_after) begin
        pulse_clr();
        chk($sformatf("v%0d clr overflow", i), overflow, 1'b0);
        chk($sformatf("v%0d clr d_valid", i), d_valid, vecs[i].exp_dv);
      end
      if (vecs[i].rd_after) begin
        pulse_rd();
        chk($sformatf("v%0d rd d_valid", i), d_valid, 1'b0);
        chk($sformatf("v%0d rd SFE", i), SFE, 1'b0);
        chk($sformatf("v%0d rd rx_data_out", i), rx_data_out, vecs[i].exp_data);
      end
    end

    // Short low glitch on an idle line must be rejected as a false start.
    @(posedge CLOCK);
    #1 Rx_raw = 1'b0;
    repeat (20) @(posedge CLOCK);
    #1 Rx_raw = 1'b1;
    repeat (100) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("glitch d_valid", d_valid, 1'b0);
    chk("glitch SFE", SFE, 1'b0);
    send_frame(8'h4B, 1'b1);
    @(negedge CLOCK);
    chk("post-glitch rx_data_out", rx_data_out, 8'h4B);
    chk("post-glitch d_valid", d_valid, 1'b1);

    // Read lands in the very cycle the next byte loads.
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (LAT) @(posedge CLOCK);
        #1 Rd_en = 1'b1;
        @(posedge CLOCK);
        #1 Rd_en = 1'b0;
      end
    join
    @(negedge CLOCK);
    chk("same-cycle rd d_valid", d_valid, 1'b1);
    chk("same-cycle rd rx_data_out", rx_data_out, 8'h77);
    chk("same-cycle rd overflow", overflow, 1'b0);

    send_frame(8'h88, 1'b1);
    @(negedge CLOCK);
    chk("pre-reset overflow", overflow, 1'b1);
    chk("pre-reset rx_data_out", rx_data_out, 8'h77);

    // Reset during data bit 4 of an all-ones frame.
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (BIT_CLKS * 5 + 32) @(posedge CLOCK);
        #1 reset = 1'b1;
        repeat (2) @(posedge CLOCK);
        #1 reset = 1'b0;
        @(negedge CLOCK);
        chk("mid-frame reset rx_data_out", rx_data_out, 8'h00);
        chk("mid-frame reset SFE", SFE, 1'b0);
        chk("mid-frame reset d_valid", d_valid, 1'b0);
        chk("mid-frame reset overflow", overflow, 1'b0);
      end
    join
    @(negedge CLOCK);
    chk("after aborted frame d_valid", d_valid, 1'b0);
    send_frame(8'h5A, 1'b1);
    @(negedge CLOCK);
    chk("post-reset rx_data_out", rx_data_out, 8'h5A);
    chk("post-reset SFE", SFE, 1'b0);
    chk("post-reset d_valid", d_valid, 1'b1);
    chk("post-reset overflow", overflow, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
